counter_ctrl: RTL and testbench

- Sequencing controller wrapped around a free-running up-counter datapath.
- Accepts run commands with a programmed terminal value and a mode (one-shot or periodic).
- Drives the count, raises a one-cycle done strobe at each terminal count, and tallies completed periods.
- Sits between a host/command source and any logic consuming cnt, replacing the bare always-enabled counter.

---
 rtl/counter_ctrl.sv | 116 +++++++++++
 tb/tb_counter_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// Run/stop sequencer around an up-counter: one-shot or periodic terminal count, done strobe, saturating lap tally.
// Optional pause input when COUNTER_CTRL_PAUSE_EN is defined; all outputs registered.
module counter_ctrl #(
  parameter int CNT_W = 4,
  parameter int LAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] period,
  input  logic             mode,
  input  logic             stop,
`ifdef COUNTER_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic [LAP_W-1:0] laps
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic [LAP_W-1:0] laps_q, laps_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             pause_w;
  logic             accept;
  logic             at_term;

`ifdef COUNTER_CTRL_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  assign accept  = start && !stop;
  assign at_term = (cnt_q == period_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (stop)                              state_d = IDLE;
        else if (!pause_w && at_term && !mode_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    mode_d   = mode_q;
    laps_d   = laps_q;
    done_d   = 1'b0;
    busy_d   = (state_d == RUN);
    case (state_q)
      IDLE: begin
        if (accept) begin
          period_d = period;
          mode_d   = mode;
          cnt_d    = '0;
          laps_d   = '0;
        end
      end
      RUN: begin
        // Terminal count wins over increment so cnt never passes period_q.
        if (!stop && !pause_w) begin
          if (at_term) begin
            done_d = 1'b1;
            if (!(&laps_q)) laps_d = laps_q + LAP_W'(1);
            if (mode_q)     cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      laps_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      laps_q   <= laps_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = done_q;
  assign laps = laps_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_counter_ctrl;
  localparam int CNT_W = 4;
  localparam int LAP_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] period;
  logic             mode;
  logic             stop;
  logic             pause_in;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             done;
  logic [LAP_W-1:0] laps;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state, derived from the command rules rather than the RTL structure.
  bit               m_run;
  int               m_cnt;
  int               m_per;
  bit               m_mode;
  int               m_laps;
  bit               m_done;

  counter_ctrl #(.CNT_W(CNT_W), .LAP_W(LAP_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .period (period),
    .mode   (mode),
    .stop   (stop),
`ifdef COUNTER_CTRL_PAUSE_EN
    .pause  (pause_in),
`endif
    .cnt    (cnt),
    .busy   (busy),
    .done   (done),
    .laps   (laps)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit pause_eff();
`ifdef COUNTER_CTRL_PAUSE_EN
    return pause_in;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_per = 0; m_mode = 0; m_laps = 0; m_done = 0;
  endtask

  task automatic model_step();
    m_done = 0;
    if (!m_run) begin
      if (start && !stop) begin
        m_per = period; m_mode = mode; m_cnt = 0; m_laps = 0; m_run = 1;
      end
    end else if (stop) begin
      m_run = 0;
    end else if (!pause_eff()) begin
      if (m_cnt == m_per) begin
        m_done = 1;
        m_laps = (m_laps == (1 << LAP_W) - 1) ? m_laps : m_laps + 1;
        if (m_mode) m_cnt = 0;
        else        m_run = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".cnt"},  32'(cnt),  32'(m_cnt));
    chk({tag, ".busy"}, 32'(busy), 32'(m_run));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".laps"}, 32'(laps), 32'(m_laps));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; pause_in = 0;
  endtask

  initial begin
    logic [CNT_W-1:0] per_seq [9];
    int               done_seen;
    per_seq = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};

    rst_n = 0; start = 1; period = 4'd7; mode = 1; stop = 0; pause_in = 0;
    model_reset();
    #4 start = 0;
    #1 rst_n = 1;
    #1;
    chk("reset.cnt", 32'(cnt), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.done", 32'(done), 0);
    chk("reset.laps", 32'(laps), 0);
    tick("reset_idle");
    chk("reset_idle.busy", 32'(busy), 0);

    // One-shot, period 3
    start = 1; period = 3; mode = 0;
    tick("os3");
    start = 0; period = 4'd9; mode = 1;
    for (int i = 1; i <= 3; i++) begin
      tick("os3");
      chk("os3.seq", 32'(cnt), 32'(i));
      chk("os3.nodone", 32'(done), 0);
    end
    tick("os3_term");
    chk("os3_term.done", 32'(done), 1);
    chk("os3_term.busy", 32'(busy), 0);
    chk("os3_term.cnt", 32'(cnt), 3);
    chk("os3_term.laps", 32'(laps), 1);
    tick("os3_after");
    chk("os3_after.done", 32'(done), 0);
    chk("os3_after.cnt", 32'(cnt), 3);

    // Periodic, period 2
    start = 1; period = 2; mode = 1;
    tick("per2");
    start = 0;
    chk("per2.seq0", 32'(cnt), 32'(per_seq[0]));
    for (int i = 1; i < 9; i++) begin
      tick("per2");
      chk("per2.seq", 32'(cnt), 32'(per_seq[i]));
      chk("per2.busy", 32'(busy), 1);
    end
    tick("per2_lap3");
    chk("per2_lap3.done", 32'(done), 1);
    chk("per2_lap3.laps", 32'(laps), 3);
    stop = 1;
    tick("per2_stop");
    stop = 0;

    // Stop at cnt=3 of a period-5 periodic run, then start+stop together
    start = 1; period = 5; mode = 1;
    tick("stop5");
    start = 0;
    repeat (3) tick("stop5");
    chk("stop5.at3", 32'(cnt), 3);
    stop = 1;
    tick("stop5_stop");
    chk("stop5_stop.busy", 32'(busy), 0);
    chk("stop5_stop.cnt", 32'(cnt), 3);
    chk("stop5_stop.done", 32'(done), 0);
    chk("stop5_stop.laps", 32'(laps), 0);
    start = 1;
    tick("startstop");
    chk("startstop.busy", 32'(busy), 0);
    idle_inputs();

    // Start while busy is ignored
    start = 1; period = 4; mode = 0;
    tick("busy4");
    period = 1;
    done_seen = 0;
    for (int i = 1; i <= 5; i++) begin
      tick("busy4");
      if (done) done_seen = i;
    end
    start = 0;
    chk("busy4.done_edge", 32'(done_seen), 5);
    chk("busy4.cnt", 32'(cnt), 4);
    tick("busy4_restart");
    idle_inputs();
    tick("busy4_restart");

    // Period 0 one-shot
    start = 1; period = 0; mode = 0;
    tick("os0");
    start = 0;
    tick("os0_term");
    chk("os0_term.done", 32'(done), 1);
    chk("os0_term.busy", 32'(busy), 0);
    tick("os0_after");
    chk("os0_after.done", 32'(done), 0);

    // Lap saturation with period 0 periodic
    start = 1; period = 0; mode = 1;
    tick("sat");
    start = 0;
    repeat (260) tick("sat");
    chk("sat.laps", 32'(laps), 255);
    chk("sat.done", 32'(done), 1);
    chk("sat.cnt", 32'(cnt), 0);
    stop = 1;
    tick("sat_stop");
    stop = 0;

    // Full-range period
    start = 1; period = 4'hF; mode = 0;
    tick("full");
    start = 0;
    repeat (15) tick("full");
    chk("full.cnt", 32'(cnt), 15);
    tick("full_term");
    chk("full_term.done", 32'(done), 1);
    chk("full_term.cnt", 32'(cnt), 15);

`ifdef COUNTER_CTRL_PAUSE_EN
    start = 1; period = 2; mode = 1;
    tick("pause");
    start = 0;
    repeat (2) tick("pause");
    pause_in = 1;
    repeat (3) begin
      tick("pause_hold");
      chk("pause_hold.cnt", 32'(cnt), 2);
      chk("pause_hold.done", 32'(done), 0);
    end
    pause_in = 0;
    tick("pause_rel");
    chk("pause_rel.done", 32'(done), 1);
    pause_in = 1;
    tick("pause2");
    stop = 1;
    tick("pause_stop");
    chk("pause_stop.busy", 32'(busy), 0);
    chk("pause_stop.done", 32'(done), 0);
    idle_inputs();
`endif

    // Reset in the middle of a run
    start = 1; period = 9; mode = 1;
    tick("midrst");
    start = 0;
    repeat (4) tick("midrst");
    rst_n = 0;
    #1;
    model_reset();
    chk("midrst.cnt", 32'(cnt), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.done", 32'(done), 0);
    chk("midrst.laps", 32'(laps), 0);
    #2 rst_n = 1;
    tick("midrst_after");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 9) < 3);
      stop     = ($urandom_range(0, 39) == 0);
      pause_in = ($urandom_range(0, 9) == 0);
      period   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom);
      mode     = 1'($urandom);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
